// File: rtl/imem_loader.sv
// imem_loader: assembles a byte-serial program image into 32-bit words written to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
   parameter int unsigned       DEPTH     = 64,
   parameter int unsigned       ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start,
   input  logic [7:0]        ByteIn,
   input  logic              ByteValid,
   output logic              ByteReady,
   output logic              WrEn,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [31:0]       WrData,
   output logic              Busy,
   output logic              CpuHold,
   output logic              Done,
   output logic              Error,
   output logic [6:0]        WordsLoaded
);
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_FIN, S_ERR} state_t;
   state_t state_q, state_d;
   logic [23:0] asm_q, asm_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] n_q, n_d, wl_q, wl_d;
   logic [7:0] sum_q, sum_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic take;
   assign ByteReady = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
   assign take = ByteValid && ByteReady;
   assign WrEn = (state_q == S_WRITE);
   assign WrAddr = addr_q;
   assign WrData = data_q;
   assign Busy = busy_q;
   assign CpuHold = busy_q;
   assign Done = done_q;
   assign Error = err_q;
   assign WordsLoaded = wl_q;
   always_comb begin
      state_d = state_q;
      asm_d = asm_q;
      idx_d = idx_q;
      n_d = n_q;
      wl_d = wl_q;
      sum_d = sum_q;
      addr_d = addr_q;
      data_d = data_q;
      busy_d = busy_q;
      done_d = done_q;
      err_d = err_q;
      case (state_q)
         S_IDLE: if (Start) begin
            state_d = S_LEN;
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d = 1'b0;
            wl_d = '0;
            idx_d = '0;
            sum_d = '0;
         end
         S_LEN: if (take) begin
            if (ByteIn == 8'd0 || 32'(ByteIn) > DEPTH) begin
               state_d = S_ERR;
               busy_d = 1'b0;
               err_d = 1'b1;
            end else begin
               state_d = S_DATA;
               n_d = ByteIn[6:0];
            end
         end
         S_DATA: if (take) begin
            sum_d = sum_q ^ ByteIn;
            idx_d = idx_q + 2'd1;
            asm_d = {ByteIn, asm_q[23:8]};
            // the fourth byte goes straight into the write register, so WrData is stable during WRITE
            if (idx_q == 2'd3) begin
               state_d = S_WRITE;
               data_d = {ByteIn, asm_q};
               addr_d = BASE_ADDR + (ADDR_W'(wl_q) << 2);
               wl_d = wl_q + 7'd1;
            end
         end
         S_WRITE: begin
            if (wl_q < n_q) state_d = S_DATA;
            else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_FIN;
               busy_d = 1'b0;
               done_d = 1'b1;
`endif
            end
         end
         S_CHK: if (take) begin
            state_d = (ByteIn == sum_q) ? S_FIN : S_ERR;
            busy_d = 1'b0;
            done_d = (ByteIn == sum_q);
            err_d = (ByteIn != sum_q);
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         asm_q <= '0;
         idx_q <= '0;
         n_q <= '0;
         wl_q <= '0;
         sum_q <= '0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         asm_q <= asm_d;
         idx_q <= idx_d;
         n_q <= n_d;
         wl_q <= wl_d;
         sum_q <= sum_d;
         addr_q <= addr_d;
         data_q <= data_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a word-list reference model.
module tb_imem_loader;
   localparam int DEPTH = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, Start = 1'b0, ByteValid = 1'b0;
   logic [7:0] ByteIn = 8'd0;
   logic ByteReady, WrEn, Busy, CpuHold, Done, Error;
   logic [63:0] WrAddr;
   logic [31:0] WrData;
   logic [6:0] WordsLoaded;
   int n_chk = 0, n_fail = 0, wr_count = 0;
   logic [31:0] prog [0:DEPTH-1];
   imem_loader dut (
      .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
      .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy),
      .CpuHold(CpuHold), .Done(Done), .Error(Error), .WordsLoaded(WordsLoaded)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (WrEn === 1'b1) wr_count++;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_ready"}, ByteReady, 0);
      check({tag, "_wren"}, WrEn, 0);
      check({tag, "_addr"}, WrAddr, 0);
      check({tag, "_data"}, WrData, 0);
      check({tag, "_busy"}, Busy, 0);
      check({tag, "_hold"}, CpuHold, 0);
      check({tag, "_done"}, Done, 0);
      check({tag, "_error"}, Error, 0);
      check({tag, "_words"}, WordsLoaded, 0);
   endtask
   task automatic pulse_start();
      ByteValid = 1'b0;
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      check("start_busy", Busy, 1);
      check("start_hold", CpuHold, 1);
      check("start_done_clr", Done, 0);
      check("start_err_clr", Error, 0);
      check("start_words_clr", WordsLoaded, 0);
   endtask
   task automatic send(input logic [7:0] b, input bit tog);
      int t = 0;
      if (tog) begin
         ByteValid = 1'b0;
         @(posedge clk); #1;
      end
      ByteIn = b;
      ByteValid = 1'b1;
      while (ByteReady !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check("ready_timeout", t < 20, 1);
      @(posedge clk); #1;
   endtask
   task automatic load(input int n, input bit tog, input bit bad_cs, input bit stray);
      int w0, t;
      bit len_err, cs_err;
      logic [7:0] x;
      w0 = wr_count;
      t = 0;
      x = 8'd0;
      len_err = (n == 0) || (n > DEPTH);
      cs_err = CSUM && bad_cs && !len_err;
      pulse_start();
      send(8'(n), tog);
      if (!len_err) begin
         for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (stray && k == 0 && b == 1) Start = 1'b1;
               send(prog[k][8*b +: 8], tog);
               Start = 1'b0;
               x ^= prog[k][8*b +: 8];
            end
            check("wr_en", WrEn, 1);
            check("ready_in_write", ByteReady, 0);
            check("wr_addr", WrAddr, 64'(4 * k));
            check("wr_data", WrData, prog[k]);
         end
         if (CSUM) send(bad_cs ? x ^ 8'h88 : x, tog);
      end
      ByteValid = 1'b0;
      while (!(Done === 1'b1 || Error === 1'b1) && t < 12) begin
         @(posedge clk); #1;
         t++;
      end
      check("end_done", Done, !(len_err || cs_err));
      check("end_error", Error, len_err || cs_err);
      check("end_busy", Busy, 0);
      check("end_hold", CpuHold, 0);
      check("end_words", WordsLoaded, len_err ? 0 : n);
      check("end_writes", wr_count - w0, len_err ? 0 : n);
      @(posedge clk); #1;
   endtask
   initial begin
      int n, w;
      #1;
      check_zero("por");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      pulse_start();
      send(8'd1, 1'b0);
      send(8'h20, 1'b0);
      send(8'h00, 1'b0);
      reset = 1'b1;
      #1;
      check_zero("mid_rst");
      w = wr_count;
      @(posedge clk); #1;
      reset = 1'b0;
      ByteValid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      ByteValid = 1'b0;
      check("mid_rst_writes", wr_count - w, 0);
      check("mid_rst_busy", Busy, 0);
      prog[0] = 32'hF2800020;
      load(1, 1'b0, 1'b0, 1'b0);
      prog[0] = 32'hF2800020;
      prog[1] = 32'hF2800021;
      prog[2] = 32'h8B010002;
      load(3, 1'b0, 1'b0, 1'b0);
      load(3, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      check_zero("idle_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      load(0, 1'b0, 1'b0, 1'b0);
      load(65, 1'b0, 1'b0, 1'b0);
      load(3, 1'b0, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      prog[0] = 32'h8B010002;
      load(1, 1'b0, 1'b0, 1'b0);
      load(1, 1'b0, 1'b1, 1'b0);
`endif
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      load(DEPTH, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 10; r++) begin
         n = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255)))
                                         : int'($urandom_range(1, 10));
         for (int i = 0; i < 10; i++) prog[i] = $urandom;
         load(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule
